// File: rtl/ac_actuator_sequencer_pkg.sv
// Shared types and constants for the AC actuator sequencer.
package ac_actuator_sequencer_pkg;

    localparam int AC_STATE_WIDTH = 2;

    typedef enum logic [AC_STATE_WIDTH-1:0] {
        AC_ST_IDLE = 2'd0,
        AC_ST_HEAT = 2'd1,
        AC_ST_COOL = 2'd2,
        AC_ST_DEAD = 2'd3
    } ac_state_e;

    // True in the states that drive a heater or compressor relay.
    function automatic logic ac_is_active(input ac_state_e s);
        return (s == AC_ST_HEAT) || (s == AC_ST_COOL);
    endfunction

endpackage

// File: rtl/ac_actuator_sequencer_if.sv
// Request/status bundle between the temperature decision logic and the
// actuator sequencer. The slave side is the sequencer itself.
interface ac_actuator_sequencer_if
    import ac_actuator_sequencer_pkg::*;
();

    logic                      enable_i;
    logic                      heat_req_i;
    logic                      cool_req_i;
    logic                      heater_on_o;
    logic                      cooler_on_o;
    logic                      fan_on_o;
    logic [AC_STATE_WIDTH-1:0] state_o;
    logic                      req_conflict_o;

    modport master (
        output enable_i, heat_req_i, cool_req_i,
        input  heater_on_o, cooler_on_o, fan_on_o, state_o, req_conflict_o
    );

    modport slave (
        input  enable_i, heat_req_i, cool_req_i,
        output heater_on_o, cooler_on_o, fan_on_o, state_o, req_conflict_o
    );

endinterface

// File: rtl/ac_cycle_timer.sv
// Loadable down-counter that stops at zero; reports when it has run out.
module ac_cycle_timer #(
    parameter int          CNT_WIDTH = 16,
    parameter int unsigned RST_VAL   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    output logic                 o_zero
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Load wins over counting; counting stops at zero instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= CNT_WIDTH'(RST_VAL);
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ac_actuator_sequencer.sv
// AC actuator sequencer: turns heat/cool request levels into relay enables
// with minimum-on time, dead time, compressor restart lockout and mutual
// exclusion. Optional fan run-on after the actuator drops is enabled by
// defining AC_FAN_OVERRUN_EN.
//
// state | meaning
// IDLE  | all relays off, waiting for a single valid request
// HEAT  | heater relay on
// COOL  | compressor relay on
// DEAD  | all relays off for DEAD_CYCLES before returning to IDLE
module ac_actuator_sequencer
    import ac_actuator_sequencer_pkg::*;
#(
    parameter int MIN_ON_CYCLES       = 8,
    parameter int DEAD_CYCLES         = 4,
    parameter int COOL_LOCKOUT_CYCLES = 12,
    parameter int FAN_OVERRUN_CYCLES  = 6,
    parameter int CNT_WIDTH           = 16
) (
    input logic                    clk_i,
    input logic                    rst_i,
    ac_actuator_sequencer_if.slave bus
);

    // Reject configurations whose cycle counts do not fit the counters.
    if ((MIN_ON_CYCLES < 1) || (DEAD_CYCLES < 1) || (FAN_OVERRUN_CYCLES < 1) ||
        (COOL_LOCKOUT_CYCLES < 0) ||
        (longint'(MIN_ON_CYCLES) >= (64'd1 << CNT_WIDTH)) ||
        (longint'(DEAD_CYCLES) >= (64'd1 << CNT_WIDTH)) ||
        (longint'(COOL_LOCKOUT_CYCLES) >= (64'd1 << CNT_WIDTH)) ||
        (longint'(FAN_OVERRUN_CYCLES) >= (64'd1 << CNT_WIDTH))) begin : g_bad_cfg
        $error("ac_actuator_sequencer: cycle parameter out of range for CNT_WIDTH");
    end

    ac_state_e            r_state;
    ac_state_e            w_state_next;
    logic [CNT_WIDTH-1:0] r_st_cnt;
    logic                 r_heater;
    logic                 r_cooler;
    logic                 r_fan;
    logic                 r_conflict;
    logic                 w_conflict_next;
    logic                 w_act_next;
    logic                 w_fan_next;
    logic                 w_lock_zero;
    logic                 w_lock_load;

    // Next-state decision; requests are only evaluated from IDLE, so a
    // HEAT<->COOL change always passes through DEAD.
    always_comb begin
        w_state_next    = r_state;
        w_conflict_next = 1'b0;
        case (r_state)
            AC_ST_IDLE: begin
                if (bus.enable_i) begin
                    if (bus.heat_req_i && bus.cool_req_i) begin
                        w_conflict_next = 1'b1;
                    end else if (bus.heat_req_i) begin
                        w_state_next = AC_ST_HEAT;
                    end else if (bus.cool_req_i && w_lock_zero) begin
                        w_state_next = AC_ST_COOL;
                    end
                end
            end
            AC_ST_HEAT: begin
                if (!bus.enable_i) begin
                    w_state_next = AC_ST_DEAD;
                end else if ((!bus.heat_req_i || bus.cool_req_i) &&
                             (r_st_cnt >= CNT_WIDTH'(MIN_ON_CYCLES - 1))) begin
                    w_state_next = AC_ST_DEAD;
                end
            end
            AC_ST_COOL: begin
                if (!bus.enable_i) begin
                    w_state_next = AC_ST_DEAD;
                end else if ((!bus.cool_req_i || bus.heat_req_i) &&
                             (r_st_cnt >= CNT_WIDTH'(MIN_ON_CYCLES - 1))) begin
                    w_state_next = AC_ST_DEAD;
                end
            end
            AC_ST_DEAD: begin
                if (r_st_cnt == CNT_WIDTH'(DEAD_CYCLES - 1)) begin
                    w_state_next = AC_ST_IDLE;
                end
            end
            default: w_state_next = AC_ST_IDLE;
        endcase
    end

    assign w_act_next  = ac_is_active(w_state_next);
    assign w_lock_load = (r_state == AC_ST_COOL) && (w_state_next != AC_ST_COOL);

    ac_cycle_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .RST_VAL   (COOL_LOCKOUT_CYCLES)
    ) u_lockout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_lock_load),
        .i_load_val (CNT_WIDTH'(COOL_LOCKOUT_CYCLES)),
        .o_zero     (w_lock_zero)
    );

`ifdef AC_FAN_OVERRUN_EN
    logic w_fan_load;
    logic w_fan_zero;

    // Loaded one short because the load edge itself is the first run-on cycle.
    assign w_fan_load = (r_heater || r_cooler) && !w_act_next;

    ac_cycle_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .RST_VAL   (0)
    ) u_fan_overrun (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_fan_load),
        .i_load_val (CNT_WIDTH'(FAN_OVERRUN_CYCLES - 1)),
        .o_zero     (w_fan_zero)
    );

    assign w_fan_next = w_act_next || w_fan_load || !w_fan_zero;
`else
    assign w_fan_next = w_act_next;
`endif

    // State register, state cycle counter and registered relay outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= AC_ST_IDLE;
            r_st_cnt   <= '0;
            r_heater   <= 1'b0;
            r_cooler   <= 1'b0;
            r_fan      <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            if (w_state_next != r_state) begin
                r_st_cnt <= '0;
            end else if (r_st_cnt != '1) begin
                r_st_cnt <= r_st_cnt + 1'b1;
            end
            r_heater   <= (w_state_next == AC_ST_HEAT);
            r_cooler   <= (w_state_next == AC_ST_COOL);
            r_fan      <= w_fan_next;
            r_conflict <= w_conflict_next;
        end
    end

    assign bus.heater_on_o    = r_heater;
    assign bus.cooler_on_o    = r_cooler;
    assign bus.fan_on_o       = r_fan;
    assign bus.state_o        = r_state;
    assign bus.req_conflict_o = r_conflict;

endmodule
